// File: rtl/merge_tree_feeder.sv
// Upstream feeder for the 8-leaf merge sorter tree: deals RUN_LEN-record runs round-robin
// onto the leaf lanes, then terminates every lane with one SENTINEL.
module merge_tree_feeder #(
  parameter int unsigned RUN_LEN  = 4,
  parameter logic [31:0] SENTINEL = 32'hFFFFFFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  total_len,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [255:0] din,
  output logic [7:0]   enq,
  input  logic [7:0]   full,
  output logic         busy,
  output logic         done,
  output logic         order_err,
  output logic [15:0]  fed_cnt
);

  localparam logic [15:0] RunLast = 16'(RUN_LEN - 1);

  typedef enum logic [1:0] {StIdle, StFeed, StPad, StDone} state_e;

  state_e      state_q;
  logic [15:0] total_q;
  logic [15:0] fed_cnt_q;
  logic [15:0] run_pos_q;
  logic [2:0]  lane_q;
  logic [31:0] prev_q;
  logic        order_err_q;
  logic        hs;
  logic [7:0]  slot_lo;

  // Lane 0 sits in the top slot of the bus, lane 7 in the bottom one.
  assign slot_lo = {~lane_q, 5'b0};

  // Enqueue is combinational so a record is pushed in the same cycle it is accepted.
  always_comb begin
    s_ready = 1'b0;
    hs      = 1'b0;
    enq     = '0;
    din     = '0;
    unique case (state_q)
      StFeed: begin
        s_ready = !full[lane_q];
        hs      = s_valid && !full[lane_q];
        if (hs) begin
          enq[lane_q]      = 1'b1;
          din[slot_lo +: 32] = s_data;
        end
      end
      StPad: begin
        if (!full[lane_q]) begin
          enq[lane_q]      = 1'b1;
          din[slot_lo +: 32] = SENTINEL;
        end
      end
      StIdle, StDone: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      total_q     <= '0;
      fed_cnt_q   <= '0;
      run_pos_q   <= '0;
      lane_q      <= '0;
      prev_q      <= '0;
      order_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            total_q     <= total_len;
            fed_cnt_q   <= '0;
            run_pos_q   <= '0;
            lane_q      <= '0;
            order_err_q <= 1'b0;
            state_q     <= (total_len == 16'd0) ? StPad : StFeed;
          end
        end
        StFeed: begin
          if (hs) begin
            fed_cnt_q <= fed_cnt_q + 16'd1;
            prev_q    <= s_data;
            // Ordering is only meaningful inside a run; a new run may restart low.
            if (run_pos_q != 16'd0 && s_data < prev_q) order_err_q <= 1'b1;
            if (run_pos_q == RunLast) begin
              run_pos_q <= '0;
              lane_q    <= lane_q + 3'd1;
            end else begin
              run_pos_q <= run_pos_q + 16'd1;
            end
            if (fed_cnt_q == total_q - 16'd1) begin
              state_q   <= StPad;
              lane_q    <= '0;
              run_pos_q <= '0;
            end
          end
        end
        StPad: begin
          if (!full[lane_q]) begin
            lane_q <= lane_q + 3'd1;
            if (lane_q == 3'd7) state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q == StFeed) || (state_q == StPad);
  assign done      = (state_q == StDone);
  assign order_err = order_err_q;
  assign fed_cnt   = fed_cnt_q;

endmodule

// File: tb/tb_merge_tree_feeder.sv
// Scoreboard bench for merge_tree_feeder: expected enqueues are queued per job and
// matched against every enq the DUT issues.
module tb_merge_tree_feeder;

  localparam int unsigned   RunLen = 4;
  localparam logic [31:0]   Sent   = 32'hFFFFFFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  total_len;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [255:0] din;
  logic [7:0]   enq;
  logic [7:0]   full;
  logic         busy;
  logic         done;
  logic         order_err;
  logic [15:0]  fed_cnt;

  always #5 clk = ~clk;

  merge_tree_feeder #(
    .RUN_LEN  (RunLen),
    .SENTINEL (Sent)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .total_len (total_len),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .din       (din),
    .enq       (enq),
    .full      (full),
    .busy      (busy),
    .done      (done),
    .order_err (order_err),
    .fed_cnt   (fed_cnt)
  );

  typedef struct packed {
    logic         last;
    logic [7:0]   enq;
    logic [255:0] din;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] stim[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          enq_cnt  = 0;
  logic        pend_done = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input int lane, input logic [31:0] d, input logic last);
    exp_t e;
    e.last = last;
    e.enq  = 8'(1 << lane);
    e.din  = '0;
    e.din[(7 - lane) * 32 +: 32] = d;
    return e;
  endfunction

  // Monitor: every enq must match the head of the scoreboard; done must follow the last sentinel.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pend_done <= 1'b0;
    end else begin
      check("done_timing", {255'd0, done}, {255'd0, pend_done});
      if (enq != 8'd0) begin
        enq_cnt <= enq_cnt + 1;
        if (exp_q.size() == 0) begin
          check("unexpected_enq", {248'd0, enq}, 256'd0);
          pend_done <= 1'b0;
        end else begin
          e = exp_q.pop_front();
          check("enq", {248'd0, enq}, {248'd0, e.enq});
          check("din", din, e.din);
          pend_done <= e.last;
        end
      end else begin
        pend_done <= 1'b0;
      end
    end
  end

  task automatic run_job(input int len, input int abort_at, input bit bp);
    logic exp_err;
    int   cnt0;
    int   t;
    int   rdy_seen;
    exp_err = 1'b0;
    for (int i = 0; i < len; i++) exp_q.push_back(mk((i / RunLen) % 8, stim[i], 1'b0));
    for (int l = 0; l < 8; l++) exp_q.push_back(mk(l, Sent, l == 7));
    cnt0 = enq_cnt;
    start = 1'b1;
    total_len = 16'(len);
    @(posedge clk) #1;
    start = 1'b0;
    check("busy_start", busy, 1);
    check("fed_clr", fed_cnt, 0);
    check("err_clr", order_err, 0);
    for (int i = 0; i < len; i++) begin
      if (abort_at >= 0 && i == abort_at) begin
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk) #1;
        s_valid = 1'b1;
        s_data = stim[i];
        #1;
        check("rst_enq", enq, 0);
        check("rst_busy", busy, 0);
        check("rst_fed", fed_cnt, 0);
        rst = 1'b0;
        s_valid = 1'b0;
        exp_q.delete();
        @(posedge clk) #1;
        return;
      end
      s_valid = 1'b1;
      s_data = stim[i];
      if (bp && i == 9) begin
        full = 8'h04;
        repeat (5) begin
          @(negedge clk);
          check("bp_ready", s_ready, 0);
          check("bp_enq", enq, 0);
          @(posedge clk) #1;
        end
        full = 8'h00;
      end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!s_ready && t < 50);
      if (!s_ready) begin
        check("hs_timeout", s_ready, 1);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk) #1;
      if (i % RunLen != 0 && stim[i] < stim[i-1]) exp_err = 1'b1;
      check("fed_cnt", fed_cnt, 256'(i + 1));
      check("order_err", order_err, {255'd0, exp_err});
    end
    s_valid = 1'b1;  // must be ignored while padding
    s_data = 32'h1234_5678;
    t = 0;
    rdy_seen = 0;
    do begin
      @(negedge clk);
      if (s_ready) rdy_seen++;
      t++;
    end while (!done && t < 40);
    s_valid = 1'b0;
    check("ready_in_pad", 256'(rdy_seen), 0);
    check("done_seen", done, 1);
    check("fed_final", fed_cnt, 256'(len));
    @(posedge clk) #1;
    check("busy_end", busy, 0);
    check("err_hold", order_err, {255'd0, exp_err});
    check("enq_total", 256'(enq_cnt - cnt0), 256'(len + 8));
    check("queue_empty", 256'(exp_q.size()), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    total_len = '0;
    s_data = '0;
    s_valid = 1'b0;
    full = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_enq0", enq, 0);
    check("rst_din", din, 0);
    check("rst_busy0", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", order_err, 0);
    check("rst_fed0", fed_cnt, 0);
    rst = 1'b0;
    @(posedge clk) #1;

    stim.delete();
    for (int i = 0; i < 32; i++) stim.push_back(32'(i));
    run_job(32, -1, 1'b0);

    stim.delete();
    for (int i = 0; i < 32; i++) stim.push_back($urandom());
    run_job(32, -1, 1'b1);

    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(32'(100 + i));
    run_job(6, -1, 1'b0);

    stim.delete();
    run_job(0, -1, 1'b0);

    stim.delete();
    stim.push_back(32'd5);
    stim.push_back(32'd7);
    stim.push_back(32'd3);
    stim.push_back(32'd9);
    run_job(4, -1, 1'b0);

    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(32'(i));
    run_job(6, -1, 1'b0);

    stim.delete();
    for (int i = 0; i < 32; i++) stim.push_back(32'(i * 3));
    run_job(32, 10, 1'b0);
    run_job(32, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/merge_tree_feeder.md
Name: merge_tree_feeder

Overview:
- Upstream stage of the 8-leaf merge sorter tree.
- Accepts a single 32-bit record stream with a valid/ready handshake and deals consecutive runs of RUN_LEN records round-robin onto the tree's 8 leaf lanes.
- Drives the tree's 256-bit data bus and one-hot enqueue, and stalls on the tree's per-lane full.
- After the last record it enqueues one SENTINEL per lane so every leaf stream is terminated and the tree drains completely.

Parameters:
- RUN_LEN, 4, records sent to one lane before advancing to the next lane (1..65535).
- SENTINEL, 32'hFFFFFFFF, end-of-stream marker pushed once into each lane.

Ports:
- clk  input  1  clock, posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a job; honoured only in IDLE.
- total_len  input  16  number of records in the job; sampled on start.
- s_data  input  32  record stream data.
- s_valid  input  1  s_data valid.
- s_ready  output  1  feeder accepts s_data this cycle.
- din  output  256  tree data bus; lane 0 occupies [255:224], lane 7 occupies [31:0].
- enq  output  8  one-hot enqueue to the tree; bit i selects lane i.
- full  input  8  per-lane full from the tree.
- busy  output  1  job in progress (FEED or PAD).
- done  output  1  one-cycle pulse when the last sentinel has been enqueued.
- order_err  output  1  sticky flag: a record within a run was smaller than its predecessor.
- fed_cnt  output  16  records accepted in the current job.

Behaviour:
- Reset (synchronous, active-high, `rst`):
  - State returns to IDLE.
  - s_ready, enq, busy, done and order_err go to 0; fed_cnt goes to 0.
  - Lane and run counters go to 0; din goes to 0.
  - Reset mid-job abandons the job immediately; nothing further is enqueued.
- States: IDLE, FEED, PAD, DONE.
- IDLE:
  - On start, latch total_len and clear fed_cnt, lane, run position and order_err.
  - Go to FEED, or to PAD if total_len==0.
- FEED:
  - s_ready = !full[lane], combinational.
  - Handshake when s_valid && s_ready. In that same cycle, enq = 1<<lane combinationally, and din carries s_data in the lane slot (all other slots 0).
  - No enq is asserted without a handshake, so zero-latency feed is the requirement.
  - Per handshake:
    - fed_cnt increments.
    - run_pos increments; when run_pos reaches RUN_LEN-1 it wraps to 0 and lane advances mod 8.
  - When fed_cnt reaches total_len-1 on a handshake, the next state is PAD with lane reset to 0.
  - The final run may be shorter than RUN_LEN; lanes not reached receive no records.
- PAD:
  - s_ready = 0.
  - For lane 0..7 in order: when !full[lane], enq = 1<<lane and din slot = SENTINEL, then advance lane.
  - A full lane stalls in place.
  - After lane 7 is enqueued, go to DONE.
- DONE:
  - done = 1 for exactly one cycle, then return to IDLE.
  - fed_cnt and order_err hold until the next start.
- busy = 1 in FEED and PAD.
- start outside IDLE is ignored.
- s_valid while not in FEED is ignored; no record is accepted.
- order_err:
  - A registered copy of the previous accepted record is kept.
  - If run_pos != 0 and s_data < prev (unsigned), set order_err. It stays set until the next start.
  - The record is still fed.
- full changes are honoured in the same cycle; lanes other than the current lane have no effect.
- fed_cnt is 16-bit, matching total_len. The job ends exactly at total_len, so there is no wrap.

Test Plan:
- Basic deal: rst, RUN_LEN=4, start with total_len=32, s_valid held with data 0..31, full=0. Required response:
  - enq sequence is lane0 x4, lane1 x4, …, lane7 x4.
  - Lane 3 receives 12,13,14,15 in din[159:128].
  - Then 8 sentinel enqs (0x01 through 0x80) in consecutive cycles.
  - done pulses on the cycle after the enq=0x80 cycle; fed_cnt=32.
- Backpressure: hold full[2]=1 for 5 cycles while lane=2. Required: s_ready=0 and enq=0 for those cycles, no records lost, order preserved once full[2] drops.
- Short job: total_len=6, RUN_LEN=4. Required: lane0 gets 4 records, lane1 gets 2, then sentinels go to lanes 0–7; total enq count is 14.
- Empty job: total_len=0. Required: straight to PAD, exactly 8 sentinel enqs, done; s_ready never asserts.
- Order error: run on lane0 with data 5,7,3,9. Required: order_err=1 from the cycle after record 3 is accepted; all 4 records still enqueued. A following start clears the flag.
- Reset mid-job: assert rst after 10 records of a 32-record job. Required: next cycle enq=0, busy=0, fed_cnt=0; a new start runs normally from lane 0.
